// File: rtl/adxl355_i2c_sequencer.sv
// adxl355_i2c_sequencer: drives an I2C master to configure an ADXL355, then burst-reads temperature and X/Y/Z on each DRDY edge
// Ports: i_clk/i_rst clock and async reset; i_en run enable; i_drdy async sensor data-ready; i_clr_err leaves ERROR;
//   i_i2c_status[0]/i_i2c_rd_data master ready and 11 read bytes; o_i2c_* master ctrl, device/register address, write data;
//   o_temp/o_x/o_y/o_z unpacked samples with o_valid strobe; o_init_done, o_busy, o_err, o_ovr_cnt status.
module adxl355_i2c_sequencer #(
  parameter logic [6:0] DEV_ADDR    = 7'h1D,
  parameter logic [2:0] CLK_RATE    = 3'd6,
  parameter logic [7:0] RANGE_VAL   = 8'h01,
  parameter logic [7:0] FILTER_VAL  = 8'h00,
  parameter int         STARTUP_CYC = 500000,
  parameter int         TIMEOUT_CYC = 200000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic        i_drdy,
  input  logic        i_clr_err,
  input  logic [31:0] i_i2c_status,
  input  logic [87:0] i_i2c_rd_data,
  output logic [31:0] o_i2c_ctrl,
  output logic [6:0]  o_i2c_dev_addr,
  output logic [7:0]  o_i2c_reg_addr,
  output logic [7:0]  o_i2c_w_data,
  output logic [11:0] o_temp,
  output logic [19:0] o_x,
  output logic [19:0] o_y,
  output logic [19:0] o_z,
  output logic        o_valid,
  output logic        o_init_done,
  output logic        o_busy,
  output logic        o_err,
  output logic [7:0]  o_ovr_cnt
);
  localparam int MAX_CYC = STARTUP_CYC > TIMEOUT_CYC ? STARTUP_CYC : TIMEOUT_CYC;
  localparam int CW = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] START_V = CW'(STARTUP_CYC);
  localparam logic [CW-1:0] TMO_V = CW'(TIMEOUT_CYC);
  typedef enum logic [3:0] {
    RESET_WAIT, INIT_ISSUE, INIT_BUSY, INIT_DONE, IDLE,
    RD_ISSUE, RD_BUSY, RD_DONE, PUBLISH, ERROR
  } state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d, op_q, op_d;
  logic en_q, en_d, rw_q, rw_d, valid_q, valid_d, done_q, done_d, pend_q, pend_d;
  logic [7:0] reg_q, reg_d, wd_q, wd_d, ovr_q, ovr_d;
  logic [87:0] cap_q, cap_d;
  logic [11:0] temp_q, temp_d;
  logic [19:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [1:0] rdy_sync_q;
  logic [2:0] drdy_sync_q;
  logic rdy, drdy_edge, unused_ok;
  assign rdy = rdy_sync_q[1];
  assign drdy_edge = drdy_sync_q[1] & ~drdy_sync_q[2];
  assign unused_ok = ^{i_i2c_status[31:1], cap_q[87:84], cap_q[51:48], cap_q[27:24], cap_q[3:0]};
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    en_d    = en_q;
    rw_d    = rw_q;
    op_d    = op_q;
    reg_d   = reg_q;
    wd_d    = wd_q;
    cap_d   = cap_q;
    temp_d  = temp_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    valid_d = 1'b0;
    done_d  = done_q;
    pend_d  = pend_q;
    ovr_d   = i_clr_err ? 8'd0 : ovr_q;
    case (state_q)
      RESET_WAIT: if (cnt_q >= START_V && i_en) state_d = INIT_ISSUE;
      INIT_ISSUE: begin
        en_d    = 1'b1;
        rw_d    = 1'b0;
        op_d    = 2'b00;
        reg_d   = idx_q == 2'd0 ? 8'h2C : idx_q == 2'd1 ? 8'h28 : 8'h2D;
        wd_d    = idx_q == 2'd0 ? RANGE_VAL : idx_q == 2'd1 ? FILTER_VAL : 8'h00;
        state_d = INIT_BUSY;
      end
      INIT_BUSY, RD_BUSY: if (!rdy) begin
        en_d    = 1'b0;
        state_d = state_q == INIT_BUSY ? INIT_DONE : RD_DONE;
      end
      INIT_DONE: if (rdy) begin
        idx_d   = idx_q < 2'd2 ? idx_q + 2'd1 : idx_q;
        done_d  = idx_q == 2'd2;
        state_d = idx_q < 2'd2 ? INIT_ISSUE : IDLE;
      end
      IDLE: if ((drdy_edge || pend_q) && i_en) begin
        pend_d  = 1'b0;
        state_d = RD_ISSUE;
      end
      RD_ISSUE: begin
        en_d    = 1'b1;
        rw_d    = 1'b1;
        op_d    = 2'b01;
        reg_d   = 8'h06;
        state_d = RD_BUSY;
      end
      RD_DONE: if (rdy) begin
        cap_d   = i_i2c_rd_data;
        state_d = PUBLISH;
      end
      PUBLISH: begin
        temp_d  = cap_q[83:72];
        x_d     = cap_q[71:52];
        y_d     = cap_q[47:28];
        z_d     = cap_q[23:4];
        valid_d = 1'b1;
        state_d = IDLE;
      end
      ERROR: if (i_clr_err) begin
        idx_d   = 2'd0;
        pend_d  = 1'b0;
        state_d = RESET_WAIT;
      end
      default: state_d = RESET_WAIT;
    endcase
    // A DRDY edge arriving while a read is publishing is simply queued, never counted as dropped
    if (drdy_edge && !(state_q inside {IDLE, ERROR})) begin
      if (!pend_q || state_q == PUBLISH) pend_d = 1'b1;
      else if (ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
    end
    if (cnt_q >= TMO_V && state_q inside {INIT_BUSY, INIT_DONE, RD_BUSY, RD_DONE}) begin
      state_d = ERROR;
      en_d    = 1'b0;
      done_d  = 1'b0;
    end
    // Leaving ERROR preloads the counter so the startup wait is skipped
    cnt_d = state_d != state_q ? (state_q == ERROR ? START_V : '0) : (&cnt_q ? cnt_q : cnt_q + CW'(1));
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state_q     <= RESET_WAIT;
      cnt_q       <= '0;
      idx_q       <= '0;
      en_q        <= 1'b0;
      rw_q        <= 1'b0;
      op_q        <= '0;
      reg_q       <= '0;
      wd_q        <= '0;
      cap_q       <= '0;
      temp_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      pend_q      <= 1'b0;
      ovr_q       <= '0;
      rdy_sync_q  <= '0;
      drdy_sync_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      en_q        <= en_d;
      rw_q        <= rw_d;
      op_q        <= op_d;
      reg_q       <= reg_d;
      wd_q        <= wd_d;
      cap_q       <= cap_d;
      temp_q      <= temp_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      pend_q      <= pend_d;
      ovr_q       <= ovr_d;
      rdy_sync_q  <= {rdy_sync_q[0], i_i2c_status[0]};
      drdy_sync_q <= {drdy_sync_q[1:0], i_drdy};
    end
  assign o_i2c_ctrl     = {25'd0, CLK_RATE, op_q, rw_q, en_q};
  assign o_i2c_dev_addr = DEV_ADDR;
  assign o_i2c_reg_addr = reg_q;
  assign o_i2c_w_data   = wd_q;
  assign o_temp         = temp_q;
  assign o_x            = x_q;
  assign o_y            = y_q;
  assign o_z            = z_q;
  assign o_valid        = valid_q;
  assign o_init_done    = done_q;
  assign o_busy         = !(state_q inside {IDLE, RESET_WAIT, ERROR});
  assign o_err          = state_q == ERROR;
  assign o_ovr_cnt      = ovr_q;
endmodule
